// File: rtl/picosoc_irqctrl_if.sv
// Memory-mapped bus between the PicoSoC CPU (master) and the interrupt
// controller register window (slave). Reads and writes complete with a
// single-cycle iomem_ready pulse; iomem_wstrb == 0 marks a read.
interface picosoc_irqctrl_if;
  logic        iomem_valid;
  logic        iomem_ready;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_addr;
  logic [31:0] iomem_wdata;
  logic [31:0] iomem_rdata;

  modport master (
    output iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
    input  iomem_ready, iomem_rdata
  );

  modport slave (
    input  iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
    output iomem_ready, iomem_rdata
  );
endinterface

// File: rtl/picosoc_irqctrl.sv
// PicoSoC interrupt controller: NUM_IRQ external lines, each configurable
// as edge/level and active-high/low, with a pending register (W1C),
// an enable mask and registered irq_out requests toward the CPU.
// Register map (byte offsets inside the 256-byte window at BASE_ADDR):
//   0x00 PENDING (R/W1C)  0x04 ENABLE (RW)  0x08 MODE (RW, 1=edge)
//   0x0C POLARITY (RW, 1=rising/high)      0x10 RAW (R, synchronized level)
// Build option: define PICOSOC_IRQCTRL_SYNC_EN to insert a two-flop
// synchronizer on every irq_in line; without it irq_in must already be
// synchronous to clk.
module picosoc_irqctrl #(
  parameter int          NUM_IRQ   = 8,
  parameter logic [31:0] BASE_ADDR = 32'h0300_0000
) (
  input  logic               clk,
  input  logic               reset,
  picosoc_irqctrl_if.slave   bus,
  input  logic [NUM_IRQ-1:0] irq_in,
  output logic [NUM_IRQ-1:0] irq_out
);

  localparam logic [7:0] OFF_PENDING  = 8'h00;
  localparam logic [7:0] OFF_ENABLE   = 8'h04;
  localparam logic [7:0] OFF_MODE     = 8'h08;
  localparam logic [7:0] OFF_POLARITY = 8'h0C;
  localparam logic [7:0] OFF_RAW      = 8'h10;

  logic [NUM_IRQ-1:0] pending, enable, mode, polarity;
  logic [NUM_IRQ-1:0] s, prev;
  logic [NUM_IRQ-1:0] active, prev_active, edge_evt, pending_nxt;

  logic               select, access, wr_en;
  logic [7:0]         offset;
  logic [31:0]        byte_mask, rd_val;
  logic [NUM_IRQ-1:0] wmask, wbits, w1c;

`ifdef PICOSOC_IRQCTRL_SYNC_EN
  logic [NUM_IRQ-1:0] sync1, sync2;

  // Two-flop synchronizer: brings the asynchronous irq_in lines into clk.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      // NOTE: non-blocking assignments let sync2 take the old sync1, so the
      // two flops form a real shift chain instead of collapsing into one.
      sync1 <= irq_in;
      sync2 <= sync1;
    end
  end

  assign s = sync2;
`else
  assign s = irq_in;
`endif

  // Bus decode, byte-masked write data and register read multiplexer.
  always_comb begin
    // NOTE: every output of this block is given a value before any branch,
    // so no path leaves one unassigned and no latch is inferred.
    select    = bus.iomem_valid && (bus.iomem_addr[31:8] == BASE_ADDR[31:8]);
    access    = select && !bus.iomem_ready;
    wr_en     = access && (bus.iomem_wstrb != 4'b0000);
    offset    = bus.iomem_addr[7:0];
    byte_mask = {{8{bus.iomem_wstrb[3]}}, {8{bus.iomem_wstrb[2]}},
                 {8{bus.iomem_wstrb[1]}}, {8{bus.iomem_wstrb[0]}}};
    wmask     = byte_mask[NUM_IRQ-1:0];
    wbits     = bus.iomem_wdata[NUM_IRQ-1:0];
    w1c       = (wr_en && offset == OFF_PENDING) ? (wbits & wmask) : '0;

    rd_val = '0;
    case (offset)
      OFF_PENDING:  rd_val = 32'(pending);
      OFF_ENABLE:   rd_val = 32'(enable);
      OFF_MODE:     rd_val = 32'(mode);
      OFF_POLARITY: rd_val = 32'(polarity);
      OFF_RAW:      rd_val = 32'(s);
      default:      rd_val = '0;
    endcase
  end

  // Event detection: the current polarity is applied to both the present and
  // the delayed level, so rewriting POLARITY can never fabricate an edge.
  // In edge mode a new event wins over a coincident W1C of the same bit.
  always_comb begin
    active      = ~(s ^ polarity);
    prev_active = ~(prev ^ polarity);
    edge_evt    = active & ~prev_active;
    pending_nxt = (mode & (edge_evt | (pending & ~w1c))) | (~mode & active);
  end

  // Register state, bus response and the registered CPU request lines.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending         <= '0;
      enable          <= '0;
      mode            <= '1;
      polarity        <= '1;
      prev            <= '0;
      irq_out         <= '0;
      bus.iomem_ready <= 1'b0;
      bus.iomem_rdata <= '0;
    end else begin
      bus.iomem_ready <= access;
      bus.iomem_rdata <= access ? rd_val : '0;
      prev            <= s;
      pending         <= pending_nxt;
      irq_out         <= pending & enable;
      if (wr_en) begin
        case (offset)
          OFF_ENABLE:   enable   <= (enable   & ~wmask) | (wbits & wmask);
          OFF_MODE:     mode     <= (mode     & ~wmask) | (wbits & wmask);
          OFF_POLARITY: polarity <= (polarity & ~wmask) | (wbits & wmask);
          default:      ;
        endcase
      end
    end
  end

  // Write-data bits above NUM_IRQ have no register behind them.
  logic unused_ok;
  assign unused_ok = ^{byte_mask, bus.iomem_wdata};

endmodule

// File: tb/tb_picosoc_irqctrl.sv
// Directed self-checking bench for picosoc_irqctrl (NUM_IRQ=8,
// BASE_ADDR=0x0300_0000). Input-to-pending latency follows the
// PICOSOC_IRQCTRL_SYNC_EN build option.
module tb_picosoc_irqctrl;

  localparam logic [31:0] BASE     = 32'h0300_0000;
  localparam logic [31:0] PENDING  = BASE + 32'h00;
  localparam logic [31:0] ENABLE   = BASE + 32'h04;
  localparam logic [31:0] MODE     = BASE + 32'h08;
  localparam logic [31:0] POLARITY = BASE + 32'h0C;
  localparam logic [31:0] RAW      = BASE + 32'h10;
  localparam logic [31:0] UNMAPPED = BASE + 32'h20;
`ifdef PICOSOC_IRQCTRL_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  logic       clk;
  logic       reset;
  logic [7:0] irq_in;
  logic [7:0] irq_out;
  int         checks;
  int         failures;
  logic [31:0] rdv;

  picosoc_irqctrl_if bus ();

  picosoc_irqctrl #(.NUM_IRQ(8), .BASE_ADDR(BASE)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .irq_in  (irq_in),
    .irq_out (irq_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Advance n rising edges, ending 1 time unit after the last one.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One bus transaction; called 1 time unit after a rising edge.
  task automatic bus_access(input logic [31:0] addr, input logic [3:0] strb,
                            input logic [31:0] wdata, output logic [31:0] rdata);
    int waited;
    bit got;
    waited = 0;
    got    = 1'b0;
    bus.iomem_valid = 1'b1;
    bus.iomem_addr  = addr;
    bus.iomem_wstrb = strb;
    bus.iomem_wdata = wdata;
    while (!got && waited < 8) begin
      @(posedge clk);
      #1;
      waited++;
      if (bus.iomem_ready) got = 1'b1;
    end
    rdata = bus.iomem_rdata;
    check("ready_latency", 32'(waited), 32'd1);
    bus.iomem_valid = 1'b0;
    bus.iomem_wstrb = 4'h0;
    @(posedge clk);
    #1;
    check("ready_single_pulse", 32'(bus.iomem_ready), 32'd0);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    logic [31:0] dummy;
    bus_access(addr, 4'hF, data, dummy);
  endtask

  task automatic rd_check(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] data;
    bus_access(addr, 4'h0, 32'h0, data);
    check(tag, data, exp);
  endtask

  initial begin
    checks          = 0;
    failures        = 0;
    reset           = 1'b1;
    irq_in          = 8'h00;
    bus.iomem_valid = 1'b0;
    bus.iomem_wstrb = 4'h0;
    bus.iomem_addr  = 32'h0;
    bus.iomem_wdata = 32'h0;
    tick(2);
    check("reset_ready", 32'(bus.iomem_ready), 32'd0);
    reset = 1'b0;
    tick(1);

    // Reset values.
    rd_check("rst_mode", MODE, 32'h0000_00FF);
    rd_check("rst_polarity", POLARITY, 32'h0000_00FF);
    rd_check("rst_pending", PENDING, 32'h0);
    rd_check("rst_enable", ENABLE, 32'h0);
    check("rst_irq_out", 32'(irq_out), 32'h0);

    // Edge mode: one-cycle pulse on irq_in[0], exact latency, sticky, W1C.
    wr(ENABLE, 32'h01);
    irq_in = 8'h01;
    tick(1);
    irq_in = 8'h00;
    tick(SYNC_LAT);
    check("edge_irq_not_yet", 32'(irq_out), 32'h00);
    tick(1);
    check("edge_irq_set", 32'(irq_out), 32'h01);
    tick(3);
    check("edge_irq_sticky", 32'(irq_out), 32'h01);
    rd_check("edge_pending", PENDING, 32'h01);
    wr(PENDING, 32'h01);
    check("edge_w1c_irq_out", 32'(irq_out), 32'h00);
    rd_check("edge_w1c_pending", PENDING, 32'h00);

    // Level mode on irq_in[3].
    wr(MODE, 32'h00);
    wr(ENABLE, 32'h08);
    irq_in = 8'h08;
    tick(SYNC_LAT + 2);
    check("level_irq_out", 32'(irq_out), 32'h08);
    rd_check("level_pending", PENDING, 32'h08);
    rd_check("level_raw", RAW, 32'h08);
    wr(PENDING, 32'h08);
    rd_check("level_w1c_no_effect", PENDING, 32'h08);
    irq_in = 8'h00;
    tick(SYNC_LAT + 1);
    rd_check("level_drop", PENDING, 32'h00);

    // Level -> edge keeps the bit; edge -> level re-evaluates it.
    irq_in = 8'h08;
    tick(SYNC_LAT + 2);
    rd_check("level_again", PENDING, 32'h08);
    wr(MODE, 32'hFF);
    irq_in = 8'h00;
    tick(SYNC_LAT + 2);
    rd_check("to_edge_sticky", PENDING, 32'h08);
    check("to_edge_irq_out", 32'(irq_out), 32'h08);
    wr(MODE, 32'h00);
    rd_check("to_level_reeval", PENDING, 32'h00);
    wr(MODE, 32'hFF);

    // Falling-edge polarity on bit 0; polarity rewrites create no event.
    wr(POLARITY, 32'hFE);
    wr(ENABLE, 32'h01);
    irq_in = 8'h01;
    tick(SYNC_LAT + 2);
    rd_check("fall_rise_no_event", PENDING, 32'h00);
    irq_in = 8'h00;
    tick(SYNC_LAT + 2);
    rd_check("fall_event", PENDING, 32'h01);
    check("fall_irq_out", 32'(irq_out), 32'h01);
    wr(PENDING, 32'h01);
    rd_check("fall_w1c", PENDING, 32'h00);
    wr(POLARITY, 32'hFF);
    rd_check("pol_flip_hi", PENDING, 32'h00);
    wr(POLARITY, 32'hFE);
    rd_check("pol_flip_lo", PENDING, 32'h00);
    wr(POLARITY, 32'hFF);
    wr(ENABLE, 32'h00);

    // Edge event on bit 2 in the same edge as its W1C: set wins.
    irq_in = 8'h04;
    tick(SYNC_LAT);
    wr(PENDING, 32'h04);
    rd_check("set_beats_w1c", PENDING, 32'h04);
    wr(PENDING, 32'h04);
    rd_check("w1c_alone", PENDING, 32'h00);
    irq_in = 8'h00;
    tick(SYNC_LAT + 2);

    // Unmapped offset, read-only RAW, masking and byte strobes.
    rd_check("unmapped_read", UNMAPPED, 32'h0);
    irq_in = 8'hA5;
    tick(SYNC_LAT + 1);
    rd_check("raw_level", RAW, 32'h0000_00A5);
    wr(RAW, 32'hFF);
    rd_check("raw_readonly", RAW, 32'h0000_00A5);
    wr(UNMAPPED, 32'hFFFF_FFFF);
    rd_check("unmapped_after_write", UNMAPPED, 32'h0);
    rd_check("multi_pending", PENDING, 32'h0000_00A5);
    check("masked_irq_out", 32'(irq_out), 32'h00);
    wr(ENABLE, 32'hFFFF_FFFF);
    rd_check("enable_upper_zero", ENABLE, 32'h0000_00FF);
    check("unmasked_irq_out", 32'(irq_out), 32'hA5);
    bus_access(ENABLE, 4'b0001, 32'h0000_000F, rdv);
    check("strb_low_irq_out", 32'(irq_out), 32'h05);
    bus_access(ENABLE, 4'b1110, 32'hFFFF_FF00, rdv);
    rd_check("strb_upper_ignored", ENABLE, 32'h0000_000F);

    // Address outside the window gets no response.
    bus.iomem_valid = 1'b1;
    bus.iomem_addr  = 32'h0400_0000;
    bus.iomem_wstrb = 4'h0;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check("foreign_no_ready", 32'(bus.iomem_ready), 32'd0);
    end
    bus.iomem_valid = 1'b0;
    irq_in = 8'h00;
    tick(SYNC_LAT + 2);

    // Reset in the middle of a write: nothing is applied.
    bus.iomem_valid = 1'b1;
    bus.iomem_addr  = ENABLE;
    bus.iomem_wstrb = 4'hF;
    bus.iomem_wdata = 32'hFF;
    #2;
    reset = 1'b1;
    #1;
    check("abort_ready", 32'(bus.iomem_ready), 32'd0);
    tick(1);
    check("abort_irq_out", 32'(irq_out), 32'h00);
    bus.iomem_valid = 1'b0;
    bus.iomem_wstrb = 4'h0;
    reset = 1'b0;
    tick(1);
    rd_check("abort_enable", ENABLE, 32'h0);
    rd_check("abort_mode", MODE, 32'h0000_00FF);
    rd_check("abort_pending", PENDING, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
